request_agent: RTL and testbench

Per-requester front end that sits directly upstream of the two-requester priority arbiter. It accepts one job at a time from a client and drives the arbiter's request line and 2-bit priority input. It ages priority while a request is denied, holds the request for the job's burst length of granted cycles, then releases. Two instances feed the arbiter: one on `ra`/`PA`/`ga`, one on `rb`/`PB`/`gb`.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/prio_ager.sv | 53 +++++
 rtl/request_agent.sv | 112 +++++++++++
 tb/tb_request_agent.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Types shared by the request agents and the two-requester priority arbiter.
package arb_pkg;

  typedef logic [1:0] prio_t;

  localparam prio_t PRIO_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OWN,
    RELEASE
  } agent_state_t;

  // Priority only ever climbs to PRIO_MAX; it must never wrap back to 0.
  function automatic prio_t prio_sat_inc(input prio_t p);
    return (p == PRIO_MAX) ? PRIO_MAX : prio_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/prio_ager.sv
// Saturating priority register with an interval counter; steps priority once
// per AGE_INTERVAL consecutive ticks.
module prio_ager
  import arb_pkg::*;
#(
  parameter int AGE_INTERVAL = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  prio_t load_val,
  input  logic  tick,
  input  logic  clr_age,
  output prio_t prio
);

  localparam int AW = $clog2(AGE_INTERVAL);

  logic [AW-1:0] age_q, age_d;
  prio_t         prio_q, prio_d;

  // load wins over clr_age, which wins over tick
  always_comb begin
    age_d  = age_q;
    prio_d = prio_q;
    if (load) begin
      prio_d = load_val;
      age_d  = '0;
    end else if (clr_age) begin
      age_d = '0;
    end else if (tick) begin
      if (age_q == AW'(AGE_INTERVAL - 1)) begin
        age_d  = '0;
        prio_d = prio_sat_inc(prio_q);
      end else begin
        age_d = age_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q  <= '0;
      prio_q <= '0;
    end else begin
      age_q  <= age_d;
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;

endmodule

// File: rtl/request_agent.sv
// Per-requester front end for the priority arbiter: accepts one job, requests
// until len grant cycles are collected, ages priority while denied, then releases.
module request_agent
  import arb_pkg::*;
#(
  parameter int BURST_W      = 4,
  parameter int AGE_INTERVAL = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  input  logic [BURST_W-1:0] job_len,
  input  prio_t              base_prio,
  output logic               job_ready,
  output logic               req,
  output prio_t              prio,
  input  logic               grant,
  output logic               done
);

  agent_state_t       state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] cnt_inc;
  logic               ager_load, ager_tick, ager_clr;
  prio_t              ager_load_val;

  assign cnt_inc = cnt_q + BURST_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    ager_load     = 1'b0;
    ager_load_val = base_prio;
    ager_tick     = 1'b0;
    ager_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          len_d     = (job_len == '0) ? BURST_W'(1) : job_len;
          cnt_d     = '0;
          ager_load = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (grant) begin
          cnt_d    = cnt_inc;
          ager_clr = 1'b1;
          state_d  = (cnt_inc == len_q) ? RELEASE : OWN;
        end else begin
          ager_tick = 1'b1;
        end
      end
      OWN: begin
        // Preemption keeps cnt, so only the remaining grants are re-requested.
        ager_clr = 1'b1;
        if (grant) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = RELEASE;
        end else begin
          state_d = WAIT;
        end
      end
      RELEASE: begin
        // Priority reads 0 again once back in IDLE.
        ager_load     = 1'b1;
        ager_load_val = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == WAIT) || (state_d == OWN);
    done_d = (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  prio_ager #(
    .AGE_INTERVAL(AGE_INTERVAL)
  ) u_ager (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ager_load),
    .load_val (ager_load_val),
    .tick     (ager_tick),
    .clr_age  (ager_clr),
    .prio     (prio)
  );

  assign job_ready = (state_q == IDLE);
  assign req       = req_q;
  assign done      = done_q;

endmodule

// File: tb/tb_request_agent.sv
// Directed bench for request_agent: drivers push the expected done pulse
// (priority and cycle) into a queue that a negedge monitor pops and checks.
module tb_request_agent;
  import arb_pkg::*;

  localparam int BW = 4;
  localparam int AI = 8;
  localparam int EW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid;
  logic [BW-1:0] job_len;
  prio_t         base_prio;
  logic          job_ready;
  logic          req;
  prio_t         prio;
  logic          grant;
  logic          done;

  int unsigned   cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [EW-1:0] exp_q[$];

  request_agent #(
    .BURST_W      (BW),
    .AGE_INTERVAL (AI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_valid (job_valid),
    .job_len   (job_len),
    .base_prio (base_prio),
    .job_ready (job_ready),
    .req       (req),
    .prio      (prio),
    .grant     (grant),
    .done      (done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_prio", prio, e[17:16]);
        check("done_cycle", cyc, e[15:0]);
      end
    end
  end

  // Offer a job, then apply grant bit gpat[i] on step i and expect req ereq[i]
  // after that edge. done is expected done_ofs edges after the accept edge.
  task automatic run_job(input logic [BW-1:0] len, input prio_t base,
                         input logic [31:0] gpat, input logic [31:0] ereq,
                         input int nsteps, input int done_ofs);
    int unsigned acc;
    job_valid = 1'b1;
    job_len   = len;
    base_prio = base;
    grant     = 1'b0;
    @(negedge clk);
    job_valid = 1'b0;
    acc       = cyc;
    check("accept_req", req, 1);
    check("accept_prio", prio, base);
    check("accept_not_ready", job_ready, 0);
    exp_q.push_back({base, 16'(acc + done_ofs)});
    for (int i = 0; i < nsteps; i++) begin
      grant = gpat[i];
      @(negedge clk);
      check("req_step", req, ereq[i]);
      if (ereq[i]) check("prio_step", prio, base);
    end
    grant = 1'b0;
    check("ready_after_job", job_ready, 1);
    check("prio_idle", prio, 0);
  endtask

  initial begin
    int unsigned acc;
    int          ep;
    rst_n     = 1'b0;
    job_valid = 1'b0;
    job_len   = '0;
    base_prio = '0;
    grant     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_prio", prio, 0);
    check("rst_done", done, 0);
    check("rst_ready", job_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // len=3 base=1, grant = req delayed one cycle
    run_job(4'd3, 2'd1, 32'b001110, 32'b000111, 6, 4);
    // len=0 behaves as len=1
    run_job(4'd0, 2'd2, 32'b001, 32'b000, 3, 1);
    // len=4 with a short preemption gap: cnt resumes, prio unchanged
    run_job(4'd4, 2'd1, 32'b001100011, 32'b000111111, 9, 7);
    // len=2 granted straight away at top priority
    run_job(4'd2, 2'd3, 32'b011, 32'b001, 4, 2);

    // aging from base 0 under 30 denied edges
    job_valid = 1'b1;
    job_len   = 4'd1;
    base_prio = 2'd0;
    grant     = 1'b0;
    @(negedge clk);
    job_valid = 1'b0;
    acc       = cyc;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ep = (k >= 3 * AI) ? 3 : k / AI;
      check("age_prio", prio, ep);
      check("age_req", req, 1);
    end
    exp_q.push_back({2'd3, 16'(acc + 31)});
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    check("age_release_req", req, 0);
    repeat (2) @(negedge clk);
    check("age_ready", job_ready, 1);

    // reset while owning: immediate clear, no done afterwards
    job_valid = 1'b1;
    job_len   = 4'd5;
    base_prio = 2'd2;
    @(negedge clk);
    job_valid = 1'b0;
    grant     = 1'b1;
    repeat (2) @(negedge clk);
    check("own_req", req, 1);
    check("own_prio", prio, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_req", req, 0);
    check("midrst_prio", prio, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", job_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    // grant in IDLE must be ignored
    repeat (6) @(negedge clk);
    check("idle_grant_req", req, 0);
    check("idle_grant_ready", job_ready, 1);
    grant = 1'b0;
    @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
